// File: rtl/seg7_pkg.sv
// Shared constants and the leading-zero suppression helper for the 7-segment scanner.
package seg7_pkg;

    localparam int          DIGIT_W    = 4;
    localparam int          MAX_DIG    = 8;
    localparam int          DIG_BITS   = MAX_DIG * DIGIT_W;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    // Bit i set = digit i is a leading zero. Digit 0 always stays visible; codes >9 count as non-zero.
    function automatic logic [MAX_DIG-1:0] lzb_mask(input logic [DIG_BITS-1:0] digits,
                                                    input int                  n_dig);
        logic               nz_seen;
        logic [MAX_DIG-1:0] mask;
        nz_seen = 1'b0;
        mask    = '0;
        for (int i = MAX_DIG - 1; i >= 1; i--) begin
            if (i < n_dig) begin
                if (digits[i*DIGIT_W +: DIGIT_W] != 4'd0) begin
                    nz_seen = 1'b1;
                end
                mask[i] = ~nz_seen;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot counter (cycles within a digit slot) and digit index, plus phase/boundary flags.
module seg7_slot_timer #(
    parameter int N_DIG = 4,
    parameter int DIV   = 1000,
    parameter int DEAD  = 16,
    localparam int CNT_W = $clog2(DIV),
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             in_dead,
    output logic             slot_end,
    output logic             frame_end,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_DIG - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign idx         = idx_q;
    assign in_dead     = (cnt_q < DEAD_CNT);
    assign slot_end    = (cnt_q == CNT_MAX);
    // Asserted for the whole last slot; qualified with slot_end it marks the commit cycle.
    assign frame_end   = (idx_q == IDX_MAX);
    assign frame_start = (idx_q == '0) && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with dead-time, leading-zero blanking
// and frame-synchronous commit of host writes.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int DIV   = 1000,
    parameter int DEAD  = 16,
    parameter int LZB   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [4*N_DIG-1:0] wr_data,
    output logic               wr_ack,
    output logic [3:0]         bcd,
    output logic [N_DIG-1:0]   dig_n,
    output logic               frame
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [IDX_W-1:0] idx;
    logic             in_dead, slot_end, frame_end, frame_start;
    logic             commit;

    seg7_slot_timer #(
        .N_DIG (N_DIG),
        .DIV   (DIV),
        .DEAD  (DEAD)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .idx         (idx),
        .in_dead     (in_dead),
        .slot_end    (slot_end),
        .frame_end   (frame_end),
        .frame_start (frame_start)
    );

    assign commit = slot_end && frame_end;

    logic [4*N_DIG-1:0] shadow_q, shadow_d;
    logic [4*N_DIG-1:0] active_q, active_d;
    logic               pend_q, pend_d;
    logic               fire_q, fire_d;
    logic               wr_ack_q, wr_ack_d;
    logic [3:0]         bcd_q, bcd_d;
    logic [N_DIG-1:0]   dig_n_q, dig_n_d;
    logic               frame_q, frame_d;

    logic [DIGIT_W-1:0] digit_a [N_DIG];
    logic [N_DIG-1:0]   blank_mask;

    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
        assign digit_a[gi] = active_q[gi*DIGIT_W +: DIGIT_W];
    end

    // Suppression looks at the displayed buffer only, so a pending write cannot change blanking early.
    assign blank_mask = (LZB != 0) ? N_DIG'(lzb_mask(DIG_BITS'(active_q), N_DIG)) : '0;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        fire_d   = 1'b0;
        if (commit) begin
            if (wr_en) begin
                active_d = wr_data;
                pend_d   = 1'b0;
                fire_d   = 1'b1;
            end else if (pend_q) begin
                active_d = shadow_q;
                pend_d   = 1'b0;
                fire_d   = 1'b1;
            end
        end else if (wr_en) begin
            shadow_d = wr_data;
            pend_d   = 1'b1;
        end
    end

    always_comb begin
        wr_ack_d = fire_q;
        frame_d  = frame_start;
        dig_n_d  = '1;
        bcd_d    = BLANK_CODE;
        if (!in_dead) begin
            dig_n_d[idx] = 1'b0;
            bcd_d        = blank_mask[idx] ? BLANK_CODE : digit_a[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            pend_q   <= 1'b0;
            fire_q   <= 1'b0;
            wr_ack_q <= 1'b0;
            bcd_q    <= BLANK_CODE;
            dig_n_q  <= '1;
            frame_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            fire_q   <= fire_d;
            wr_ack_q <= wr_ack_d;
            bcd_q    <= bcd_d;
            dig_n_q  <= dig_n_d;
            frame_q  <= frame_d;
        end
    end

    assign wr_ack = wr_ack_q;
    assign bcd    = bcd_q;
    assign dig_n  = dig_n_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: two instances (DEAD=2/LZB=1 and DEAD=0/LZB=0)
// checked every cycle against a cycle-number based model, plus literal spot checks.
module tb_seg7_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0;

    logic        a_ack, b_ack, a_frame, b_frame;
    logic [3:0]  a_bcd, b_bcd, a_dig_n, b_dig_n;

    seg7_scan_ctrl #(.N_DIG(N), .DIV(DIV), .DEAD(2), .LZB(1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ack(a_ack), .bcd(a_bcd), .dig_n(a_dig_n), .frame(a_frame)
    );

    seg7_scan_ctrl #(.N_DIG(N), .DIV(DIV), .DEAD(0), .LZB(0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ack(b_ack), .bcd(b_bcd), .dig_n(b_dig_n), .frame(b_frame)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int phase    = 0;

    // Model state: what the display holds and what the host has queued.
    logic [3:0] m_active [N];
    logic [3:0] m_shadow [N];
    bit         m_pend;
    bit         m_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s phase=%0d cyc=%0d got=%h expected=%h", name, phase, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_dig_n(input int c, input int dead);
        int slot = (c / DIV) % N;
        if ((c % DIV) < dead) return 4'b1111;
        return ~(4'b0001 << slot);
    endfunction

    function automatic logic [3:0] exp_bcd(input int c, input int dead, input bit lzb);
        int slot = (c / DIV) % N;
        bit all_zero = 1'b1;
        if ((c % DIV) < dead) return 4'hF;
        if (lzb && slot > 0) begin
            for (int j = slot; j < N; j++) if (m_active[j] != 4'd0) all_zero = 1'b0;
            if (all_zero) return 4'hF;
        end
        return m_active[slot];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 4'd0;
            m_shadow[i] = 4'd0;
        end
        m_pend = 1'b0;
        m_ack  = 1'b0;
        cyc    = 0;
    endtask

    task automatic literal_checks();
        if (phase == 0) begin
            case (cyc)
                0:   begin chk("lit_frame0", a_frame, 1); chk("lit_b_dig0", b_dig_n, 4'b1110); end
                2:   begin chk("lit_dig2", a_dig_n, 4'b1110); chk("lit_bcd2", a_bcd, 4'h0); end
                7:   chk("lit_dig7", a_dig_n, 4'b1110);
                8:   chk("lit_dead8", a_dig_n, 4'b1111);
                10:  begin chk("lit_dig10", a_dig_n, 4'b1101); chk("lit_bcd10", a_bcd, 4'hF);
                           chk("lit_b_bcd10", b_bcd, 4'h0); end
                26:  chk("lit_dig26", a_dig_n, 4'b0111);
                31:  chk("lit_ack31", a_ack, 0);
                32:  begin chk("lit_ack32", a_ack, 1); chk("lit_frame32", a_frame, 1); end
                34:  chk("lit_bcd34", a_bcd, 4'h7);
                42:  chk("lit_bcd42", a_bcd, 4'h0);
                50:  chk("lit_bcd50", a_bcd, 4'h4);
                58:  chk("lit_bcd58", a_bcd, 4'hF);
                96:  chk("lit_ack96", a_ack, 1);
                97:  chk("lit_ack97", a_ack, 0);
                98:  chk("lit_bcd98", a_bcd, 4'h8);
                122: chk("lit_bcd122", a_bcd, 4'h5);
                128: chk("lit_ack128", a_ack, 1);
                138: chk("lit_bcd138", a_bcd, 4'h0);
                154: chk("lit_bcd154", a_bcd, 4'h9);
                default: ;
            endcase
        end else if (phase == 2) begin
            if (cyc == 32) chk("lit_noack_after_rst", a_ack, 0);
            if (cyc == 2)  chk("lit_bcd_after_rst", a_bcd, 4'h0);
        end
    endtask

    // One clock: drive, sample #1 after the edge, compare both instances, advance the model.
    task automatic step(input bit we, input logic [15:0] d);
        int  cnt, slot;
        bit  commit;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        #1;
        chk("a_dig_n", a_dig_n, exp_dig_n(cyc, 2));
        chk("a_bcd",   a_bcd,   exp_bcd(cyc, 2, 1'b1));
        chk("a_frame", a_frame, (cyc % (N * DIV)) == 0);
        chk("a_ack",   a_ack,   m_ack);
        chk("b_dig_n", b_dig_n, exp_dig_n(cyc, 0));
        chk("b_bcd",   b_bcd,   exp_bcd(cyc, 0, 1'b0));
        chk("b_frame", b_frame, (cyc % (N * DIV)) == 0);
        chk("b_ack",   b_ack,   m_ack);
        literal_checks();
        if (a_ack) $display("ack phase=%0d cyc=%0d", phase, cyc);
        if (we)    $display("write phase=%0d cyc=%0d data=%h", phase, cyc, d);
        cnt    = cyc % DIV;
        slot   = (cyc / DIV) % N;
        commit = (cnt == DIV - 1) && (slot == N - 1);
        m_ack  = 1'b0;
        if (commit) begin
            if (we) begin
                for (int i = 0; i < N; i++) m_active[i] = d[i*4 +: 4];
                m_ack = 1'b1;
            end else if (m_pend) begin
                for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
                m_ack = 1'b1;
            end
            m_pend = 1'b0;
        end else if (we) begin
            for (int i = 0; i < N; i++) m_shadow[i] = d[i*4 +: 4];
            m_pend = 1'b1;
        end
        cyc++;
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dig_n", a_dig_n, 4'b1111);
        chk("rst_bcd",   a_bcd,   4'hF);
        chk("rst_ack",   a_ack,   0);
        chk("rst_frame", a_frame, 0);
        chk("rst_b_dig_n", b_dig_n, 4'b1111);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        do_reset();

        phase = 0;
        while (cyc < 160) begin
            case (cyc)
                5:       step(1'b1, 16'h0407);
                67:      step(1'b1, 16'h1234);
                74:      step(1'b1, 16'h5678);
                127:     step(1'b1, 16'h9000);
                default: step(1'b0, 16'h0000);
            endcase
        end

        do_reset();
        phase = 1;
        while (cyc <= 13) begin
            if (cyc == 5) step(1'b1, 16'h0321);
            else          step(1'b0, 16'h0000);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_dig_n", a_dig_n, 4'b1111);
        chk("async_rst_bcd",   a_bcd,   4'hF);
        chk("async_rst_b_dig_n", b_dig_n, 4'b1111);
        do_reset();

        phase = 2;
        while (cyc < 70) step(1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout phase=%0d cyc=%0d", phase, cyc);
        $fatal(1, "timeout");
    end

endmodule
